// File: rtl/ped_req_arbiter_pkg.sv
// ped_pkg: shared defaults, direction index type and arbiter FSM states
package ped_pkg;
    localparam int N_DIR_DEF = 4;
    localparam int LONG_CYCLES_DEF = 150_000_000;
    typedef logic [$clog2(N_DIR_DEF)-1:0] dir_t;
    typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/ped_req_arbiter_if.sv
// ped_req_arbiter_if: button inputs and request handshake between arbiter and phase controller
interface ped_req_arbiter_if import ped_pkg::*; #(parameter int N_DIR = N_DIR_DEF);
    logic [N_DIR-1:0]         btn_db;
    logic                     req_valid;
    logic [$clog2(N_DIR)-1:0] req_dir;
    logic                     req_urgent;
    logic                     req_ready;
    logic [N_DIR-1:0]         pending;
    modport master (input btn_db, req_ready, output req_valid, req_dir, req_urgent, pending);
    modport slave  (output btn_db, req_ready, input req_valid, req_dir, req_urgent, pending);
endinterface

// File: rtl/ped_req_arbiter_hold_timer.sv
// ped_hold_timer: saturating press-duration counter with a one-cycle long-press pulse
module ped_hold_timer import ped_pkg::*; #(
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic hit
);
    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(LONG_CYCLES);
    logic [CW-1:0] cnt;
    // count while held, stop at LIM, restart from zero on release
    always_ff @(posedge clk)
        if (rst || !btn) cnt <= '0;
        else if (cnt != LIM) cnt <= cnt + 1'b1;
    assign hit = btn && cnt == LIM - 1'b1;
endmodule

// File: rtl/ped_req_arbiter.sv
// ped_req_arbiter: latches pedestrian presses and offers them round-robin, urgent first
module ped_req_arbiter import ped_pkg::*; #(
    parameter int N_DIR = N_DIR_DEF,
    parameter int LONG_CYCLES = LONG_CYCLES_DEF
) (
    input logic clk,
    input logic rst,
    ped_req_arbiter_if.master bus
);
    localparam int DW = $clog2(N_DIR);
    typedef logic [DW-1:0] idx_t;
    state_t state, state_nx;
    logic [N_DIR-1:0] prev, pend, urg, rise, hit, clr, cls;
    idx_t last, last_nx, dir, dir_nx, win;
    logic urg_r, urg_nx, xfer;

    function automatic idx_t rr_pick(input logic [N_DIR-1:0] req, input idx_t from);
        idx_t pick;
        logic found;
        pick = from;
        found = 1'b0;
        for (int k = 1; k <= N_DIR; k++) begin
            int idx;
            idx = (int'(from) + k) % N_DIR;
            if (!found && req[idx]) begin
                pick = idx_t'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar i = 0; i < N_DIR; i++) begin : g_hold
        ped_hold_timer #(.LONG_CYCLES(LONG_CYCLES)) u_hold (
            .clk(clk),
            .rst(rst),
            .btn(bus.btn_db[i]),
            .hit(hit[i])
        );
    end

    assign rise = bus.btn_db & ~prev;
    assign xfer = state == OFFER && bus.req_ready;
    assign cls = |(pend & urg) ? pend & urg : pend;
    assign win = rr_pick(cls, last);

    // one-hot clear mask for the direction being transferred this edge
    always_comb begin
        clr = '0;
        clr[dir] = xfer;
    end

    // request bookkeeping (new presses win over a simultaneous clear) and offer registers
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            prev  <= '0;
            pend  <= '0;
            urg   <= '0;
            last  <= idx_t'(N_DIR - 1);
            dir   <= '0;
            urg_r <= 1'b0;
        end else begin
            state <= state_nx;
            prev  <= bus.btn_db;
            pend  <= (pend & ~clr) | rise | hit;
            urg   <= (urg & ~clr) | hit;
            last  <= last_nx;
            dir   <= dir_nx;
            urg_r <= urg_nx;
        end

    // capture a winner from IDLE, hold it through OFFER, note the grant on transfer
    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        urg_nx   = urg_r;
        last_nx  = last;
        if (state == IDLE) begin
            if (|pend) begin
                state_nx = OFFER;
                dir_nx   = win;
                urg_nx   = urg[win];
            end
        end else if (xfer) begin
            state_nx = IDLE;
            last_nx  = dir;
        end
    end

    assign bus.req_valid  = state == OFFER;
    assign bus.req_dir    = dir;
    assign bus.req_urgent = urg_r;
    assign bus.pending    = pend;
endmodule
